// File: rtl/flaf_mon_pkg.sv
// Shared definitions for the FLAF convergence monitor: FSM state codes,
// Q4.12 threshold defaults and the unsigned saturation helper.
package flaf_mon_pkg;

    typedef enum logic [1:0] {
        WARMUP    = 2'd0,
        TRACK     = 2'd1,
        CONVERGED = 2'd2,
        DIVERGED  = 2'd3
    } mon_state_t;

    localparam logic [15:0] CONV_THR_Q412 = 16'h0010;
    localparam logic [15:0] EXIT_THR_Q412 = 16'h0040;
    localparam logic [15:0] DIV_THR_Q412  = 16'h4000;

    // Clamp an unsigned value to the largest value representable in w bits.
    function automatic logic [63:0] sat_u(input logic [63:0] x, input int unsigned w);
        logic [63:0] lim;
        lim = (64'd1 << w) - 64'd1;
        return (x > lim) ? lim : x;
    endfunction

endpackage

// File: rtl/flaf_err_square.sv
// Registered error square: rounds e*e from Q(2*QP) back to Q(QP) and
// saturates to WIDTH unsigned bits; the valid bit travels alongside.
module flaf_err_square #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned QP    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] error_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] sq_out
);
    import flaf_mon_pkg::*;

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned RW = PW + 1;

    logic signed [PW-1:0] sq_c;
    logic [RW-1:0]        rnd_c;

    // Full-precision square plus half-LSB rounding constant.
    always_comb begin
        sq_c  = PW'($signed(error_in)) * PW'($signed(error_in));
        rnd_c = {1'b0, sq_c} + RW'(64'd1 << (QP - 1));
    end

    // Square register; clear discards any in-flight sample.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid_out <= 1'b0;
            sq_out    <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                sq_out <= WIDTH'(sat_u(64'(rnd_c >> QP), WIDTH));
            end
        end
    end

endmodule

// File: rtl/flaf_mse_monitor.sv
// Convergence monitor for the FLAF filter: input register, squared error,
// EWMA mean-square error and a WARMUP/TRACK/CONVERGED/DIVERGED FSM.
// Optional peak |error| tracker enabled by defining FLAF_MON_PEAK_EN.
module flaf_mse_monitor #(
    parameter int unsigned      WIDTH      = 16,
    parameter int unsigned      QP         = 12,
    parameter int unsigned      LAMBDA_SH  = 6,
    parameter int unsigned      WARMUP_LEN = 64,
    parameter int unsigned      HOLD_LEN   = 256,
    parameter logic [WIDTH-1:0] CONV_THR   = WIDTH'(flaf_mon_pkg::CONV_THR_Q412),
    parameter logic [WIDTH-1:0] EXIT_THR   = WIDTH'(flaf_mon_pkg::EXIT_THR_Q412),
    parameter logic [WIDTH-1:0] DIV_THR    = WIDTH'(flaf_mon_pkg::DIV_THR_Q412),
    parameter int unsigned      CNT_W      = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] error_in,
    output logic [WIDTH-1:0] mse_out,
    output logic [1:0]       state_out,
    output logic             converged,
    output logic             diverged,
    output logic [CNT_W-1:0] conv_cycles,
    output logic [WIDTH-1:0] peak_err
);
    import flaf_mon_pkg::*;

    localparam int unsigned ACC_W  = WIDTH + LAMBDA_SH;
    localparam int unsigned WARM_W = $clog2(WARMUP_LEN + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_LEN + 1);

    logic             v_r;
    logic [WIDTH-1:0] e_r;
    logic             sq_v;
    logic [WIDTH-1:0] sq_r;
    logic             acc_v;
    logic [ACC_W-1:0] acc;

    mon_state_t       state_q, state_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frozen_q, frozen_d;
    logic             conv_q, div_q;

    // Input register; clear wins over a simultaneous valid sample.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            v_r <= 1'b0;
            e_r <= '0;
        end else begin
            v_r <= valid_in;
            if (valid_in) begin
                e_r <= error_in;
            end
        end
    end

    flaf_err_square #(
        .WIDTH (WIDTH),
        .QP    (QP)
    ) u_square (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .valid_in  (v_r),
        .error_in  (e_r),
        .valid_out (sq_v),
        .sq_out    (sq_r)
    );

    // EWMA accumulator: acc <- acc - acc/2^L + sq, frozen on invalid cycles.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_v <= 1'b0;
            acc   <= '0;
        end else begin
            acc_v <= sq_v;
            if (sq_v) begin
                acc <= acc - (acc >> LAMBDA_SH) + ACC_W'(sq_r);
            end
        end
    end

    assign mse_out = acc[ACC_W-1:LAMBDA_SH];

    // Next-state, hold/warm-up counters and convergence-time counter.
    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        frozen_d = frozen_q;
        if (acc_v) begin
            if (!frozen_q && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            case (state_q)
                WARMUP: begin
                    warm_d = warm_q + WARM_W'(1);
                    if (warm_d == WARM_W'(WARMUP_LEN)) begin
                        state_d = TRACK;
                        hold_d  = '0;
                    end
                end
                TRACK: begin
                    if (mse_out > DIV_THR) begin
                        state_d = DIVERGED;
                    end else if (mse_out < CONV_THR) begin
                        hold_d = hold_q + HOLD_W'(1);
                        if (hold_d == HOLD_W'(HOLD_LEN)) begin
                            state_d = CONVERGED;
                        end
                    end else begin
                        hold_d = '0;
                    end
                end
                CONVERGED: begin
                    if (mse_out > DIV_THR) begin
                        state_d = DIVERGED;
                    end else if (mse_out >= EXIT_THR) begin
                        state_d = TRACK;
                        hold_d  = '0;
                    end
                end
                DIVERGED: begin
                    state_d = DIVERGED;
                end
                default: begin
                    state_d = WARMUP;
                end
            endcase
            if ((state_d == CONVERGED) && (state_q != CONVERGED)) begin
                frozen_d = 1'b1;
            end
        end
    end

    // FSM state, counters and registered status flags.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q  <= WARMUP;
            warm_q   <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            frozen_q <= 1'b0;
            conv_q   <= 1'b0;
            div_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            warm_q   <= warm_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            frozen_q <= frozen_d;
            conv_q   <= (state_d == CONVERGED);
            div_q    <= (state_d == DIVERGED);
        end
    end

    assign state_out   = state_q;
    assign converged   = conv_q;
    assign diverged    = div_q;
    assign conv_cycles = cnt_q;

`ifdef FLAF_MON_PEAK_EN
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH-1:0] abs_c;
    logic [WIDTH-1:0] peak_q;

    // Magnitude of the registered error, most-negative code clamped.
    always_comb begin
        abs_c = e_r;
        if (e_r[WIDTH-1]) begin
            abs_c = (e_r == NEG_MIN) ? POS_MAX : (~e_r + WIDTH'(1));
        end
    end

    // Running maximum of |error| since restart.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            peak_q <= '0;
        end else if (v_r && (abs_c > peak_q)) begin
            peak_q <= abs_c;
        end
    end

    assign peak_err = peak_q;
`else
    assign peak_err = '0;
`endif

endmodule

// File: tb/tb_flaf_mse_monitor.sv
// Self-checking bench for flaf_mse_monitor. A sample-level reference model
// records its outputs per clock edge; DUT outputs are compared against the
// model history shifted by the pipeline latency (mse 2 edges, flags 3, peak 1).
module tb_flaf_mse_monitor;

    localparam int MAXC = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        valid_in;
    logic [15:0] error_in;
    logic [15:0] mse_out;
    logic [1:0]  state_out;
    logic        converged;
    logic        diverged;
    logic [23:0] conv_cycles;
    logic [15:0] peak_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int h_mse[MAXC];
    int h_st[MAXC];
    int h_cnt[MAXC];
    int h_pk[MAXC];

    int m_acc, m_st, m_warm, m_hold, m_cnt, m_frozen, m_pk;

    always #5 clk = ~clk;

    flaf_mse_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .valid_in    (valid_in),
        .error_in    (error_in),
        .mse_out     (mse_out),
        .state_out   (state_out),
        .converged   (converged),
        .diverged    (diverged),
        .conv_cycles (conv_cycles),
        .peak_err    (peak_err)
    );

    function automatic void model_clear();
        m_acc = 0; m_st = 0; m_warm = 0; m_hold = 0;
        m_cnt = 0; m_frozen = 0; m_pk = 0;
    endfunction

    // One accepted sample: square/round/saturate, EWMA, then state rules.
    function automatic void model_step(input int e);
        longint sq;
        int sqr, mse, a;
        sq  = longint'(e) * longint'(e);
        sqr = int'((sq + 64'd2048) / 4096);
        if (sqr > 65535) sqr = 65535;
        m_acc = m_acc - (m_acc / 64) + sqr;
        mse = m_acc / 64;
        if (m_frozen == 0 && m_cnt < 24'hFFFFFF) m_cnt++;
        case (m_st)
            0: begin m_warm++; if (m_warm == 64) begin m_st = 1; m_hold = 0; end end
            1: begin
                if (mse > 'h4000) m_st = 3;
                else if (mse < 'h10) begin m_hold++; if (m_hold == 256) m_st = 2; end
                else m_hold = 0;
            end
            2: begin
                if (mse > 'h4000) m_st = 3;
                else if (mse >= 'h40) begin m_st = 1; m_hold = 0; end
            end
            default: ;
        endcase
        if (m_st == 2) m_frozen = 1;
`ifdef FLAF_MON_PEAK_EN
        a = (e < 0) ? -e : e;
        if (a > 32767) a = 32767;
        if (a > m_pk) m_pk = a;
`else
        a = 0;
        m_pk = a;
`endif
    endfunction

    function automatic void store(input int k);
        h_mse[k] = m_acc / 64;
        h_st[k]  = m_st;
        h_cnt[k] = m_cnt;
        h_pk[k]  = m_pk;
    endfunction

    // Drive one clock edge and update the model; returns #1 after the edge.
    task automatic drive(input logic r, input logic c, input logic v, input logic [15:0] e);
        reset = r; clear = c; valid_in = v; error_in = e;
        @(posedge clk);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end
        if (r || c) begin
            model_clear();
            for (int j = 0; j < 4; j++) if (cyc - j >= 0) store(cyc - j);
        end else begin
            if (v) model_step(int'($signed(e)));
            store(cyc);
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 16'h0);
        n_checks += 6;
        if (mse_out !== 16'h0) begin n_errors++; $display("FAIL reset_mse got=%0h exp=0", mse_out); end
        if (state_out !== 2'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", state_out); end
        if (converged !== 1'b0) begin n_errors++; $display("FAIL reset_conv got=%0b exp=0", converged); end
        if (diverged !== 1'b0) begin n_errors++; $display("FAIL reset_div got=%0b exp=0", diverged); end
        if (conv_cycles !== 24'h0) begin n_errors++; $display("FAIL reset_cnt got=%0d exp=0", conv_cycles); end
        if (peak_err !== 16'h0) begin n_errors++; $display("FAIL reset_peak got=%0h exp=0", peak_err); end
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 16'h1000);
        drive(1'b1, 1'b0, 1'b1, 16'h1000);
        n_checks += 4;
        if (mse_out !== 16'h0) begin n_errors++; $display("FAIL midreset_mse got=%0h exp=0", mse_out); end
        if (state_out !== 2'd0) begin n_errors++; $display("FAIL midreset_state got=%0d exp=0", state_out); end
        if (conv_cycles !== 24'h0) begin n_errors++; $display("FAIL midreset_cnt got=%0d exp=0", conv_cycles); end
        if (peak_err !== 16'h0) begin n_errors++; $display("FAIL midreset_peak got=%0h exp=0", peak_err); end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 16'h0);
        n_checks++;
        if (mse_out !== 16'h0) begin n_errors++; $display("FAIL midreset_flush got=%0h exp=0", mse_out); end
    endtask

    task automatic test_converge();
        int r_edge, first_edge;
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        r_edge = cyc - 1;
        first_edge = -1;
        for (int i = 0; i < 330; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'h0);
            if (converged === 1'b1 && first_edge < 0) first_edge = cyc - 1;
            n_checks += 2;
            if (state_out !== 2'(h_st[cyc-4])) begin n_errors++; $display("FAIL conv_state cyc=%0d got=%0d exp=%0d", cyc, state_out, h_st[cyc-4]); end
            if (mse_out !== 16'h0) begin n_errors++; $display("FAIL conv_mse cyc=%0d got=%0h exp=0", cyc, mse_out); end
        end
        n_checks += 3;
        if (first_edge != r_edge + 323) begin n_errors++; $display("FAIL conv_time got=%0d exp=%0d", first_edge - r_edge, 323); end
        if (conv_cycles !== 24'd320) begin n_errors++; $display("FAIL conv_cycles got=%0d exp=320", conv_cycles); end
        if (state_out !== 2'd2) begin n_errors++; $display("FAIL conv_final got=%0d exp=2", state_out); end
    endtask

    task automatic test_exit();
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'h0400);
            n_checks += 3;
            if (mse_out !== 16'(h_mse[cyc-3])) begin n_errors++; $display("FAIL exit_mse cyc=%0d got=%0h exp=%0h", cyc, mse_out, h_mse[cyc-3]); end
            if (state_out !== 2'(h_st[cyc-4])) begin n_errors++; $display("FAIL exit_state cyc=%0d got=%0d exp=%0d", cyc, state_out, h_st[cyc-4]); end
            if (converged !== (h_st[cyc-4] == 2)) begin n_errors++; $display("FAIL exit_conv cyc=%0d got=%0b exp=%0b", cyc, converged, h_st[cyc-4] == 2); end
        end
        n_checks += 3;
        if (state_out !== 2'd1) begin n_errors++; $display("FAIL exit_final got=%0d exp=1", state_out); end
        if (converged !== 1'b0) begin n_errors++; $display("FAIL exit_flag got=%0b exp=0", converged); end
        if (conv_cycles !== 24'd320) begin n_errors++; $display("FAIL exit_cnt got=%0d exp=320", conv_cycles); end
    endtask

    task automatic test_constant();
        int prev;
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        prev = 0;
        for (int i = 0; i < 2000; i++) begin
            drive(1'b0, 1'b0, 1'b1, 16'h1000);
            n_checks += 3;
            if (mse_out !== 16'(h_mse[cyc-3])) begin n_errors++; $display("FAIL const_mse cyc=%0d got=%0h exp=%0h", cyc, mse_out, h_mse[cyc-3]); end
            if (int'(mse_out) < prev) begin n_errors++; $display("FAIL const_mono cyc=%0d got=%0d exp>=%0d", cyc, mse_out, prev); end
            if (state_out !== 2'(h_st[cyc-4])) begin n_errors++; $display("FAIL const_state cyc=%0d got=%0d exp=%0d", cyc, state_out, h_st[cyc-4]); end
            prev = int'(mse_out);
        end
        n_checks += 2;
        if (mse_out < 16'd4032 || mse_out > 16'd4096) begin n_errors++; $display("FAIL const_level got=%0d exp=4032..4096", mse_out); end
        if (state_out !== 2'd1) begin n_errors++; $display("FAIL const_final got=%0d exp=1", state_out); end
    endtask

    task automatic test_diverge();
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 64; i++) drive(1'b0, 1'b0, 1'b1, 16'h0);
        for (int i = 0; i < 90; i++) begin
            drive(1'b0, 1'b0, 1'b1, (i < 40) ? 16'h8000 : 16'h0);
            n_checks += 3;
            if (mse_out !== 16'(h_mse[cyc-3])) begin n_errors++; $display("FAIL div_mse cyc=%0d got=%0h exp=%0h", cyc, mse_out, h_mse[cyc-3]); end
            if (state_out !== 2'(h_st[cyc-4])) begin n_errors++; $display("FAIL div_state cyc=%0d got=%0d exp=%0d", cyc, state_out, h_st[cyc-4]); end
            if (diverged !== (h_st[cyc-4] == 3)) begin n_errors++; $display("FAIL div_flag cyc=%0d got=%0b exp=%0b", cyc, diverged, h_st[cyc-4] == 3); end
        end
        n_checks++;
        if (diverged !== 1'b1) begin n_errors++; $display("FAIL div_sticky got=%0b exp=1", diverged); end
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        n_checks += 5;
        if (mse_out !== 16'h0) begin n_errors++; $display("FAIL div_clr_mse got=%0h exp=0", mse_out); end
        if (state_out !== 2'd0) begin n_errors++; $display("FAIL div_clr_state got=%0d exp=0", state_out); end
        if (diverged !== 1'b0) begin n_errors++; $display("FAIL div_clr_flag got=%0b exp=0", diverged); end
        if (conv_cycles !== 24'h0) begin n_errors++; $display("FAIL div_clr_cnt got=%0d exp=0", conv_cycles); end
        if (peak_err !== 16'h0) begin n_errors++; $display("FAIL div_clr_peak got=%0h exp=0", peak_err); end
    endtask

    task automatic test_toggle();
        int c_edge, first_edge;
        logic v;
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        c_edge = cyc - 1;
        first_edge = -1;
        for (int i = 0; i < 680; i++) begin
            v = (i % 2) == 1;
            drive(1'b0, 1'b0, v, v ? 16'h0 : 16'($urandom));
            if (converged === 1'b1 && first_edge < 0) first_edge = cyc - 1;
            n_checks += 2;
            if (state_out !== 2'(h_st[cyc-4])) begin n_errors++; $display("FAIL tog_state cyc=%0d got=%0d exp=%0d", cyc, state_out, h_st[cyc-4]); end
            if (conv_cycles !== 24'(h_cnt[cyc-4])) begin n_errors++; $display("FAIL tog_cnt cyc=%0d got=%0d exp=%0d", cyc, conv_cycles, h_cnt[cyc-4]); end
        end
        n_checks += 2;
        if (first_edge != c_edge + 643) begin n_errors++; $display("FAIL tog_time got=%0d exp=643", first_edge - c_edge); end
        if (conv_cycles !== 24'd320) begin n_errors++; $display("FAIL tog_cycles got=%0d exp=320", conv_cycles); end
    endtask

    task automatic test_peak();
        logic [15:0] vals [4];
        logic [15:0] exps [4];
        vals = '{16'd100, 16'hF448, 16'd2000, 16'h8000};
`ifdef FLAF_MON_PEAK_EN
        exps = '{16'd100, 16'd3000, 16'd3000, 16'd32767};
`else
        exps = '{16'd0, 16'd0, 16'd0, 16'd0};
`endif
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, vals[i]);
            drive(1'b0, 1'b0, 1'b0, 16'h7FFF);
            n_checks++;
            if (peak_err !== exps[i]) begin n_errors++; $display("FAIL peak_%0d got=%0d exp=%0d", i, peak_err, exps[i]); end
        end
    endtask

    task automatic test_clear_valid();
        drive(1'b0, 1'b1, 1'b1, 16'h1000);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 16'h0);
        n_checks++;
        if (mse_out !== 16'h0) begin n_errors++; $display("FAIL clrv_drop got=%0h exp=0", mse_out); end
        drive(1'b0, 1'b0, 1'b1, 16'h1000);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        n_checks++;
        if (mse_out !== 16'h0) begin n_errors++; $display("FAIL lat_early got=%0h exp=0", mse_out); end
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        n_checks++;
        if (mse_out !== 16'd64) begin n_errors++; $display("FAIL lat_mse got=%0d exp=64", mse_out); end
    endtask

    task automatic test_random();
        logic v, c;
        int e, sel;
        drive(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 399) == 0);
            sel = $urandom_range(0, 99);
            if (((i / 600) % 2) == 0 || sel < 80) e = int'($urandom_range(0, 500)) - 250;
            else if (sel < 95) e = int'($urandom_range(0, 6000)) - 3000;
            else e = int'($signed(16'($urandom)));
            drive(1'b0, c, v, 16'(e));
            n_checks += 6;
            if (mse_out !== 16'(h_mse[cyc-3])) begin n_errors++; $display("FAIL rnd_mse cyc=%0d got=%0h exp=%0h", cyc, mse_out, h_mse[cyc-3]); end
            if (state_out !== 2'(h_st[cyc-4])) begin n_errors++; $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", cyc, state_out, h_st[cyc-4]); end
            if (converged !== (h_st[cyc-4] == 2)) begin n_errors++; $display("FAIL rnd_conv cyc=%0d got=%0b", cyc, converged); end
            if (diverged !== (h_st[cyc-4] == 3)) begin n_errors++; $display("FAIL rnd_div cyc=%0d got=%0b", cyc, diverged); end
            if (conv_cycles !== 24'(h_cnt[cyc-4])) begin n_errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, conv_cycles, h_cnt[cyc-4]); end
            if (peak_err !== 16'(h_pk[cyc-2])) begin n_errors++; $display("FAIL rnd_peak cyc=%0d got=%0d exp=%0d", cyc, peak_err, h_pk[cyc-2]); end
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; valid_in = 1'b0; error_in = 16'h0;
        model_clear();
        test_reset();
        test_converge();
        test_exit();
        test_constant();
        test_diverge();
        test_toggle();
        test_peak();
        test_clear_valid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
